imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Single-ported instruction memory. It is the responder end of the fetch-stage instruction memory interface: address and read_n come in, data goes out.
- Returns one 32-bit word per cycle with fixed 1-cycle latency. Honours read_n hold semantics.
- Includes a boot-load port that fills the memory after reset. imem_ready_o is used by the top level to hold the core in reset until loading is finished.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words. Must be a power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be aligned to DEPTH_WORDS*4.
- LOAD_ENABLE, 1: 1 = enter LOAD after reset; 0 = enter RUN directly, with contents from an init file.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- imem_addr_i  in  32  fetch byte address
- imem_read_n_i  in  1  0 = read at imem_addr_i this cycle; 1 = hold output
- imem_data_o  out  32  instruction word
- imem_fault_o  out  1  registered; qualifies imem_data_o as misaligned or out-of-range
- imem_ready_o  out  1  1 in RUN state
- load_valid_i  in  1  load beat valid
- load_ready_o  out  1  load beat accepted when valid & ready
- load_addr_i  in  32  load byte address
- load_data_i  in  32  load word
- load_be_i  in  4  byte enables
- load_last_i  in  1  final beat of image
- load_count_o  out  16  number of accepted in-range beats
- load_err_o  out  1  sticky; an out-of-range or misaligned load beat was seen

Behaviour:
- Reset is synchronous, active-low, on reset_n; clock is clk.
- Reset values:
  - imem_data_o=0, imem_fault_o=0, load_count_o=0, load_err_o=0.
  - State = LOAD if LOAD_ENABLE, else RUN. imem_ready_o and load_ready_o follow the state.
- Memory contents are never cleared by reset. Reset mid-load returns to LOAD with count 0 and keeps already-written words.
- Address decode: off = addr - BASE_ADDR (32-bit wrap); index = off[log2(DEPTH_WORDS)+1:2].
  - In range iff off < DEPTH_WORDS*4.
  - Misaligned iff addr[1:0] != 0.
- States:
  - LOAD: load_ready_o=1, imem_ready_o=0.
  - RUN: load_ready_o=0, imem_ready_o=1.
  - LOAD -> RUN on the accepted beat with load_last_i=1, including an erroneous last beat.
  - RUN is terminal until reset.
- LOAD beat (valid & ready):
  - In-range and aligned: write bytes where load_be_i[k]=1 at the edge; load_count_o += 1, saturating at 16'hFFFF.
  - Otherwise: no write, load_err_o <= 1.
  - be=0 still counts as a beat.
- RUN read, imem_read_n_i=0 at edge t:
  - At t+1, imem_data_o = mem[index] and imem_fault_o = 0 if in range and aligned.
  - Otherwise imem_data_o = 0 and imem_fault_o = 1.
- RUN, imem_read_n_i=1: imem_data_o and imem_fault_o hold their previous values indefinitely, which supports a multi-cycle fetch stall.
- In LOAD: fetch inputs ignored; imem_data_o=0 and imem_fault_o=0 held.
- In RUN: load inputs ignored; load_count_o and load_err_o frozen.
- No read/write collision is possible, because writes occur only in LOAD and reads only in RUN.
- First RUN cycle: a read presented in that cycle returns data at the next edge. No extra bubble.

Decomposition:
- Shared package imem_pkg:
  - state encoding (IMEM_LOAD, IMEM_RUN)
  - XLEN=32
  - NOP word 32'h0000_0013, for top-level use
  - alignment helper function
- One sub-module, imem_storage: synchronous RAM with read-enable and 4-bit byte-enable write, 1-cycle read. imem_responder holds the FSM, decode, counters and fault logic.

Test Plan:
- Load, then read: 4 beats at 0x0,0x4,0x8,0xC with data 0x11111111..0x44444444, be=F, last on the 4th.
  - load_count_o=4, imem_ready_o=1 the next cycle.
  - read_n=0 at addr 0x8 -> imem_data_o=0x33333333 one cycle later, fault=0.
- Byte enables: load 0x0 = 0xAABBCCDD be=F, then 0x0 = 0x00000011 be=0001 last -> read 0x0 returns 0xAABBCC11.
- Stall hold: read 0x4 (0x22222222), then read_n=1 for 3 cycles with addr changed to 0xC -> data stays 0x22222222 all 3 cycles.
- Faults:
  - read 0x6 -> data 0, fault=1.
  - read DEPTH_WORDS*4 -> data 0, fault=1.
  - next read 0x0 -> fault=0 with correct data.
  - load beat at 0x1000 with DEPTH=1024 -> load_err_o=1, load_count_o unchanged.
- Reset mid-load: 2 beats, reset_n=0 for 1 cycle, then 1 beat at 0x8 with last -> count=1, RUN entered; addr 0x0 still holds the pre-reset word.
- LOAD_ENABLE=0: after reset imem_ready_o=1 immediately; load_valid_i=1 is ignored with load_ready_o=0; reads return init-file contents.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory responder: state encoding,
// word width, the NOP word and an alignment helper.
package imem_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0 -- used by the top level to fill the fetch stage while the core is held
    localparam logic [XLEN-1:0] IMEM_NOP = 32'h0000_0013;

    typedef enum logic {
        IMEM_LOAD,
        IMEM_RUN
    } imem_state_e;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch and boot-load signal bundle between the core/loader (master) and the
// instruction memory (slave).
interface imem_responder_if;
    import imem_pkg::*;

    logic [XLEN-1:0] imem_addr_i;
    logic            imem_read_n_i;
    logic [XLEN-1:0] imem_data_o;
    logic            imem_fault_o;
    logic            imem_ready_o;

    logic            load_valid_i;
    logic            load_ready_o;
    logic [XLEN-1:0] load_addr_i;
    logic [XLEN-1:0] load_data_i;
    logic [3:0]      load_be_i;
    logic            load_last_i;
    logic [15:0]     load_count_o;
    logic            load_err_o;

    modport slave (
        input  imem_addr_i, imem_read_n_i,
        output imem_data_o, imem_fault_o, imem_ready_o,
        input  load_valid_i, load_addr_i, load_data_i, load_be_i, load_last_i,
        output load_ready_o, load_count_o, load_err_o
    );

    modport master (
        output imem_addr_i, imem_read_n_i,
        input  imem_data_o, imem_fault_o, imem_ready_o,
        output load_valid_i, load_addr_i, load_data_i, load_be_i, load_last_i,
        input  load_ready_o, load_count_o, load_err_o
    );

endinterface

// File: rtl/imem_storage.sv
// Single-port word RAM with per-byte write enables and a registered,
// read-enabled output (holds its last value when not reading).
module imem_storage
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic [AW-1:0]   i_addr,
    input  logic            i_re,
    input  logic [3:0]      i_we,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [3:0][7:0] r_mem [DEPTH_WORDS];
    logic [XLEN-1:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (i_we[k]) begin
                r_mem[i_addr][k] <= i_wdata[8*k +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: boot-load FSM, address decode, fault and load
// bookkeeping around a single-port byte-writable RAM.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned   DEPTH_WORDS = 1024,
    parameter logic [31:0]   BASE_ADDR   = 32'h0000_0000,
    parameter bit            LOAD_ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    imem_responder_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    imem_state_e     r_state;
    logic            r_imem_ready;
    logic            r_load_ready;
    logic            r_fault;
    logic            r_data_sel;
    logic [15:0]     r_load_count;
    logic            r_load_err;

    logic [XLEN-1:0] w_fetch_off;
    logic [XLEN-1:0] w_load_off;
    logic            w_fetch_ok;
    logic            w_load_ok;
    logic            w_in_load;
    logic [AW-1:0]   w_addr;
    logic [3:0]      w_we;
    logic            w_re;
    logic [XLEN-1:0] w_rdata;

    // BASE_ADDR is aligned to the memory size, so offset alignment equals address alignment
    assign w_fetch_off = bus.imem_addr_i - BASE_ADDR;
    assign w_load_off  = bus.load_addr_i - BASE_ADDR;
    assign w_fetch_ok  = (w_fetch_off[XLEN-1:AW+2] == '0) && is_word_aligned(w_fetch_off);
    assign w_load_ok   = (w_load_off[XLEN-1:AW+2] == '0) && is_word_aligned(w_load_off);

    assign w_in_load = (r_state == IMEM_LOAD);
    assign w_addr    = w_in_load ? w_load_off[AW+1:2] : w_fetch_off[AW+1:2];
    assign w_we      = (w_in_load && bus.load_valid_i && w_load_ok) ? bus.load_be_i : '0;
    assign w_re      = !w_in_load && !bus.imem_read_n_i && w_fetch_ok;

    imem_storage #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_storage (
        .clk     (clk),
        .i_addr  (w_addr),
        .i_re    (w_re),
        .i_we    (w_we),
        .i_wdata (bus.load_data_i),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= LOAD_ENABLE ? IMEM_LOAD : IMEM_RUN;
            r_imem_ready <= !LOAD_ENABLE;
            r_load_ready <= LOAD_ENABLE;
            r_fault      <= 1'b0;
            r_data_sel   <= 1'b0;
            r_load_count <= '0;
            r_load_err   <= 1'b0;
        end else begin
            case (r_state)
                IMEM_LOAD: begin
                    if (bus.load_valid_i) begin
                        if (w_load_ok) begin
                            if (r_load_count != '1) begin
                                r_load_count <= r_load_count + 16'd1;
                            end
                        end else begin
                            r_load_err <= 1'b1;
                        end
                        if (bus.load_last_i) begin
                            r_state      <= IMEM_RUN;
                            r_imem_ready <= 1'b1;
                            r_load_ready <= 1'b0;
                        end
                    end
                end
                IMEM_RUN: begin
                    // RAM output holds across stalls; r_data_sel gates it to zero on a fault
                    if (!bus.imem_read_n_i) begin
                        r_fault    <= !w_fetch_ok;
                        r_data_sel <= w_fetch_ok;
                    end
                end
                default: r_state <= IMEM_RUN;
            endcase
        end
    end

    assign bus.imem_data_o  = r_data_sel ? w_rdata : '0;
    assign bus.imem_fault_o = r_fault;
    assign bus.imem_ready_o = r_imem_ready;
    assign bus.load_ready_o = r_load_ready;
    assign bus.load_count_o = r_load_count;
    assign bus.load_err_o   = r_load_err;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed load/read/fault/reset sequences plus a
// randomized phase, all checked cycle by cycle against a behavioural model.
module tb_imem_responder;

    localparam int unsigned D1 = 1024;
    localparam logic [31:0] B1 = 32'h0000_0000;
    localparam logic [31:0] B2 = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    imem_responder_if bus1 ();
    imem_responder_if bus2 ();

    imem_responder #(.DEPTH_WORDS(D1), .BASE_ADDR(B1), .LOAD_ENABLE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus1));

    imem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(B2), .LOAD_ENABLE(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input logic [31:0] mask = '1);
        n_checks++;
        if ((act & mask) !== (exp & mask)) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, act, exp, mask, $time);
        end
    endtask

    // ---------------- behavioural model of dut (LOAD_ENABLE=1) ----------------
    bit          m_live = 0;
    bit          m_running;
    int unsigned m_count;
    bit          m_err;
    logic [31:0] m_data, m_mask;
    bit          m_fault;
    bit   [31:0] m_mem   [D1];
    bit   [31:0] m_known [D1];

    function automatic bit addr_ok(input logic [31:0] a, output int unsigned idx);
        logic [31:0] off;
        off = a - B1;
        idx = off / 4;
        return (a % 4 == 0) && (off < D1 * 4);
    endfunction

    task automatic model_step();
        int unsigned idx;
        if (!reset_n) begin
            m_live = 1; m_running = 0; m_count = 0; m_err = 0;
            m_data = '0; m_mask = '1; m_fault = 0;
        end else if (m_live) begin
            if (!m_running) begin
                if (bus1.load_valid_i) begin
                    if (addr_ok(bus1.load_addr_i, idx)) begin
                        for (int k = 0; k < 4; k++) begin
                            if (bus1.load_be_i[k]) begin
                                m_mem[idx][8*k +: 8]   = bus1.load_data_i[8*k +: 8];
                                m_known[idx][8*k +: 8] = 8'hFF;
                            end
                        end
                        if (m_count < 65535) m_count++;
                    end else begin
                        m_err = 1;
                    end
                    if (bus1.load_last_i) m_running = 1;
                end
            end else if (!bus1.imem_read_n_i) begin
                if (addr_ok(bus1.imem_addr_i, idx)) begin
                    m_data = m_mem[idx]; m_mask = m_known[idx]; m_fault = 0;
                end else begin
                    m_data = '0; m_mask = '1; m_fault = 1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("data",   bus1.imem_data_o, m_data, m_mask);
            chk("fault",  32'(bus1.imem_fault_o), 32'(m_fault));
            chk("ready",  32'(bus1.imem_ready_o), 32'(m_running));
            chk("lready", 32'(bus1.load_ready_o), 32'(!m_running));
            chk("count",  32'(bus1.load_count_o), m_count);
            chk("err",    32'(bus1.load_err_o), 32'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) step();
        reset_n = 1'b1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input bit last);
        bus1.load_valid_i = 1'b1; bus1.load_addr_i = a; bus1.load_data_i = d;
        bus1.load_be_i = be; bus1.load_last_i = last;
        step();
        bus1.load_valid_i = 1'b0; bus1.load_last_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus1.imem_read_n_i = 1'b0; bus1.imem_addr_i = a;
        step();
        bus1.imem_read_n_i = 1'b1;
    endtask

    task automatic rd2(input logic [31:0] a);
        bus2.imem_read_n_i = 1'b0; bus2.imem_addr_i = a;
        step();
        bus2.imem_read_n_i = 1'b1;
    endtask

    initial begin
        bus1.imem_addr_i = '0; bus1.imem_read_n_i = 1'b1;
        bus1.load_valid_i = 1'b0; bus1.load_addr_i = '0; bus1.load_data_i = '0;
        bus1.load_be_i = '0; bus1.load_last_i = 1'b0;
        bus2.imem_addr_i = '0; bus2.imem_read_n_i = 1'b1;
        bus2.load_valid_i = 1'b0; bus2.load_addr_i = '0; bus2.load_data_i = '0;
        bus2.load_be_i = '0; bus2.load_last_i = 1'b0;

        do_reset(2);
        chk("rst_data",   bus1.imem_data_o, 32'h0);
        chk("rst_ready",  32'(bus1.imem_ready_o), 32'd0);
        chk("rst_lready", 32'(bus1.load_ready_o), 32'd1);
        chk("rst_count",  32'(bus1.load_count_o), 32'd0);

        // LOAD_ENABLE=0 instance: runs straight away and ignores the load port
        chk("d2_ready",  32'(bus2.imem_ready_o), 32'd1);
        chk("d2_lready", 32'(bus2.load_ready_o), 32'd0);
        bus2.load_valid_i = 1'b1; bus2.load_addr_i = B2 + 32'h1; bus2.load_last_i = 1'b1;
        bus2.load_be_i = 4'hF; bus2.load_data_i = 32'hDEADBEEF;
        repeat (3) step();
        bus2.load_valid_i = 1'b0; bus2.load_last_i = 1'b0;
        chk("d2_count", 32'(bus2.load_count_o), 32'd0);
        chk("d2_err",   32'(bus2.load_err_o), 32'd0);
        chk("d2_ready2", 32'(bus2.imem_ready_o), 32'd1);
        rd2(B2 + 32'hC);
        chk("d2_f_in",  32'(bus2.imem_fault_o), 32'd0);
        rd2(B2 + 32'h40);
        chk("d2_f_top", 32'(bus2.imem_fault_o), 32'd1);
        chk("d2_d_top", bus2.imem_data_o, 32'h0);
        rd2(B2 - 32'h4);
        chk("d2_f_low", 32'(bus2.imem_fault_o), 32'd1);
        rd2(B2 + 32'h8);
        chk("d2_f_in2", 32'(bus2.imem_fault_o), 32'd0);

        // load then read
        beat(32'h0, 32'h11111111, 4'hF, 0);
        beat(32'h4, 32'h22222222, 4'hF, 0);
        beat(32'h8, 32'h33333333, 4'hF, 0);
        chk("not_ready_yet", 32'(bus1.imem_ready_o), 32'd0);
        beat(32'hC, 32'h44444444, 4'hF, 1);
        chk("cnt4",   32'(bus1.load_count_o), 32'd4);
        chk("ready1", 32'(bus1.imem_ready_o), 32'd1);
        rd(32'h8);
        chk("rd8", bus1.imem_data_o, 32'h33333333);
        chk("rd8_f", 32'(bus1.imem_fault_o), 32'd0);

        // stall hold
        rd(32'h4);
        chk("rd4", bus1.imem_data_o, 32'h22222222);
        bus1.imem_addr_i = 32'hC;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold", bus1.imem_data_o, 32'h22222222);
        end

        // faults
        rd(32'h6);
        chk("mis_d", bus1.imem_data_o, 32'h0);
        chk("mis_f", 32'(bus1.imem_fault_o), 32'd1);
        rd(D1 * 4);
        chk("oor_d", bus1.imem_data_o, 32'h0);
        chk("oor_f", 32'(bus1.imem_fault_o), 32'd1);
        rd(32'h0);
        chk("rec_d", bus1.imem_data_o, 32'h11111111);
        chk("rec_f", 32'(bus1.imem_fault_o), 32'd0);
        chk("run_lr", 32'(bus1.load_ready_o), 32'd0);

        // byte enables and an out-of-range load beat
        do_reset(1);
        beat(32'h0, 32'hAABBCCDD, 4'hF, 0);
        beat(32'h1000, 32'h12345678, 4'hF, 0);
        chk("lerr",   32'(bus1.load_err_o), 32'd1);
        chk("lerr_c", 32'(bus1.load_count_o), 32'd1);
        beat(32'h0, 32'h00000011, 4'b0001, 1);
        rd(32'h0);
        chk("be", bus1.imem_data_o, 32'hAABBCC11);

        // reset mid-load keeps memory contents
        do_reset(1);
        beat(32'h0, 32'h5555AAAA, 4'hF, 0);
        beat(32'h4, 32'h66666666, 4'hF, 0);
        do_reset(1);
        beat(32'h8, 32'h77777777, 4'hF, 1);
        chk("mid_cnt", 32'(bus1.load_count_o), 32'd1);
        chk("mid_rdy", 32'(bus1.imem_ready_o), 32'd1);
        rd(32'h0);
        chk("mid_keep", bus1.imem_data_o, 32'h5555AAAA);

        // randomized load then randomized fetch traffic
        do_reset(1);
        for (int i = 0; i < 200; i++) begin
            int unsigned sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h1000 + ($urandom_range(0, 255) << 2);
            else if (sel == 1) a = ($urandom_range(0, 127) << 2) | $urandom_range(1, 3);
            else               a = $urandom_range(0, 127) << 2;
            bus1.load_valid_i = ($urandom_range(0, 3) != 0);
            bus1.load_addr_i  = a;
            bus1.load_data_i  = $urandom;
            bus1.load_be_i    = 4'($urandom_range(0, 15));
            bus1.load_last_i  = 1'b0;
            step();
        end
        beat(32'h0, 32'hC0DE0000, 4'hF, 1);
        for (int i = 0; i < 300; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            bus1.imem_read_n_i = ($urandom_range(0, 2) == 0);
            if (sel == 0)      bus1.imem_addr_i = $urandom;
            else if (sel == 1) bus1.imem_addr_i = ($urandom_range(0, 127) << 2) | $urandom_range(1, 3);
            else               bus1.imem_addr_i = $urandom_range(0, 127) << 2;
            bus1.load_valid_i = $urandom_range(0, 1);
            bus1.load_addr_i  = $urandom_range(0, 127) << 2;
            bus1.load_last_i  = $urandom_range(0, 1);
            step();
        end
        bus1.imem_read_n_i = 1'b1;
        bus1.load_valid_i  = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
